// File: rtl/sysarr_ws_stream_core_if.sv
// Streaming handshake bundle between the operand scheduler,
// the weight-stationary systolic core and the writeback buffer.
interface sysarr_ws_stream_core_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 32
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                 mode;
    logic                 start;
    logic                 w_valid;
    logic                 w_ready;
    logic [RW-1:0]        w_row;
    logic [COLS*DW-1:0]   w_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic [COLS*AW-1:0]   ps_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [COLS*AW-1:0]   out_data;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;

    modport master (
        output mode, start, w_valid, w_row, w_data,
        output in_valid, in_data, ps_data, in_last, out_ready,
        input  w_ready, in_ready, out_valid, out_data,
        input  busy, done, cfg_err
    );

    modport slave (
        input  mode, start, w_valid, w_row, w_data,
        input  in_valid, in_data, ps_data, in_last, out_ready,
        output w_ready, in_ready, out_valid, out_data,
        output busy, done, cfg_err
    );
endinterface

// File: rtl/sysarr_ws_stream_core.sv
// Weight-stationary ROWS x COLS systolic core with streaming
// backpressure, optional partial-sum add and load/run/drain control.
module sysarr_ws_stream_core #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 32
) (
    input logic                   clk,
    input logic                   nRST,
    sysarr_ws_stream_core_if.slave bus
);
    localparam int L  = ROWS + COLS;
    localparam int CW = $clog2(ROWS + COLS + 2);
    localparam int YW = COLS * AW;
    localparam logic [YW-1:0] YM = YW'({AW{1'b1}});

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t r_state, w_state_nxt;
    logic   r_done, r_err, w_done_nxt, w_err_nxt;
    logic   w_w_ready, w_in_ready;

    logic [ROWS-1:0] r_mask, w_row_oh, w_mask_set;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;
    logic [YW-1:0]   r_out_data, w_sum;
    logic            w_adv, w_acc_w, w_acc_in, w_out_hs;

    logic signed [DW-1:0] r_w   [ROWS][COLS];
    logic signed [DW-1:0] r_act [ROWS][COLS];
    logic [AW-1:0]        r_psum[ROWS][COLS];
    logic signed [DW-1:0] w_xin [ROWS][COLS];
    logic [AW-1:0]        w_pnxt[ROWS][COLS];

    // Token pipeline: tk[k] is the vector accepted k+1 edges ago.
    logic                r_tv [L];
    logic                r_tm [L];
    logic [ROWS*DW-1:0]  r_tx [L];
    logic [YW-1:0]       r_tps[L];
    logic [YW-1:0]       r_ty [L];
    logic [YW-1:0]       w_ynext[L];

    assign w_adv    = !r_out_valid || bus.out_ready;
    assign w_acc_w  = (r_state == S_LOAD) && bus.w_valid;
    assign w_acc_in = (r_state == S_RUN) && w_adv && bus.in_valid;
    assign w_out_hs = r_out_valid && bus.out_ready;
    assign w_row_oh = ROWS'(1) << bus.w_row;
    assign w_mask_set = r_mask | (w_acc_w ? w_row_oh : '0);

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_w_ready   = 1'b0;
        w_in_ready  = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                w_w_ready = 1'b1;
                if (bus.start) begin
                    if (&w_mask_set) w_state_nxt = S_RUN;
                    else             w_err_nxt   = 1'b1;
                end
            end
            S_RUN: begin
                w_in_ready = w_adv;
                if (w_acc_in && bus.in_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_LOAD;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nRST) begin
            r_state <= S_LOAD;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // PE (r,c): activation moves right, partial sum moves down.
    for (genvar r = 0; r < ROWS; r++) begin : g_r
        for (genvar c = 0; c < COLS; c++) begin : g_c
            logic signed [2*DW-1:0] w_prod;
            logic signed [AW-1:0]   w_ext;
            if (c == 0) begin : g_x0
                assign w_xin[r][c] = r_tx[r][r*DW +: DW];
            end else begin : g_xn
                assign w_xin[r][c] = r_act[r][c-1];
            end
            assign w_prod = w_xin[r][c] * r_w[r][c];
            assign w_ext  = w_prod;
            if (r == 0) begin : g_p0
                assign w_pnxt[r][c] = w_ext;
            end else begin : g_pn
                assign w_pnxt[r][c] = r_psum[r-1][c] + w_ext;
            end
        end
    end

    // Column c leaves the grid while its token sits at stage ROWS+c.
    for (genvar k = 0; k < L; k++) begin : g_y
        if (k >= ROWS) begin : g_ins
            localparam int C = k - ROWS;
            assign w_ynext[k] = (r_ty[k] & ~(YM << (C*AW)))
                              | (YW'(r_psum[ROWS-1][C]) << (C*AW));
        end else begin : g_pass
            assign w_ynext[k] = r_ty[k];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_sum
        assign w_sum[c*AW +: AW] = w_ynext[L-1][c*AW +: AW]
            + (r_tm[L-1] ? r_tps[L-1][c*AW +: AW] : AW'(0));
    end

    always_ff @(posedge clk) begin
        if (nRST) begin
            r_mask      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_w[r][c]    <= '0;
                    r_act[r][c]  <= '0;
                    r_psum[r][c] <= '0;
                end
            end
            for (int k = 0; k < L; k++) begin
                r_tv[k]  <= 1'b0;
                r_tm[k]  <= 1'b0;
                r_tx[k]  <= '0;
                r_tps[k] <= '0;
                r_ty[k]  <= '0;
            end
        end else begin
            r_cnt <= r_cnt + CW'(w_acc_in) - CW'(w_out_hs);
            if (w_acc_w) begin
                r_mask <= w_mask_set;
                for (int c = 0; c < COLS; c++)
                    r_w[bus.w_row][c] <= bus.w_data[c*DW +: DW];
            end
            if (w_adv) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        r_act[r][c]  <= w_xin[r][c];
                        r_psum[r][c] <= w_pnxt[r][c];
                    end
                end
                r_tv[0]  <= w_acc_in;
                r_tm[0]  <= bus.mode;
                r_tx[0]  <= bus.in_data;
                r_tps[0] <= bus.ps_data;
                r_ty[0]  <= '0;
                for (int k = 1; k < L; k++) begin
                    r_tv[k]  <= r_tv[k-1];
                    r_tm[k]  <= r_tm[k-1];
                    r_tx[k]  <= r_tx[k-1];
                    r_tps[k] <= r_tps[k-1];
                    r_ty[k]  <= w_ynext[k-1];
                end
                r_out_valid <= r_tv[L-1];
                if (r_tv[L-1]) r_out_data <= w_sum;
            end
        end
    end

    assign bus.w_ready   = w_w_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = (r_state != S_LOAD);
    assign bus.done      = r_done;
    assign bus.cfg_err   = r_err;
endmodule

// File: tb/tb_sysarr_ws_stream_core.sv
// Directed scoreboard bench for the 2x2 configuration of the
// weight-stationary systolic core.
module tb_sysarr_ws_stream_core;
    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int DW   = 8;
    localparam int AW   = 32;

    logic clk  = 1'b0;
    logic nRST = 1'b1;
    always #5 clk = ~clk;

    sysarr_ws_stream_core_if #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)
    ) bus ();

    sysarr_ws_stream_core #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)
    ) dut (
        .clk (clk),
        .nRST(nRST),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          W[2][2];
    logic [63:0] q[$];
    logic [63:0] held;
    bit          held_v = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input int x0, input int x1,
                                          input bit m, input int p0,
                                          input int p1);
        int y[2];
        for (int c = 0; c < 2; c++) begin
            y[c] = x0 * W[0][c] + x1 * W[1][c];
            if (m) y[c] += (c == 0) ? p0 : p1;
        end
        return {32'(y[1]), 32'(y[0])};
    endfunction

    // Output monitor: pops on each handshake, checks hold under stall.
    always @(negedge clk) begin
        if (!nRST) begin
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) chk("out_data", bus.out_data, q.pop_front());
            end
            if (bus.out_valid && !bus.out_ready) begin
                if (held_v) chk("stall_hold", bus.out_data, held);
                held   = bus.out_data;
                held_v = 1;
            end else begin
                held_v = 0;
            end
        end else begin
            held_v = 0;
        end
    end

    task automatic load_row(input int r, input int a, input int b);
        W[r][0] = a;
        W[r][1] = b;
        bus.w_valid = 1'b1;
        bus.w_row   = r[0];
        bus.w_data  = {8'(b), 8'(a)};
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit exp_err, input bit exp_busy);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("cfg_err", 64'(bus.cfg_err), 64'(exp_err));
        chk("busy", 64'(bus.busy), 64'(exp_busy));
        @(posedge clk); #1;
        chk("cfg_err_pulse", 64'(bus.cfg_err), 64'd0);
    endtask

    task automatic send(input int x0, input int x1, input bit m,
                        input int p0, input int p1, input bit last);
        bit acc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = {8'(x1), 8'(x0)};
        bus.ps_data  = {32'(p1), 32'(p0)};
        bus.mode     = m;
        bus.in_last  = last;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back(model(x0, x1, m, p0, p1));
                acc = 1;
            end
            @(posedge clk); #1;
        end
        chk("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        chk({tag, "_done"}, 64'(seen), 64'd1);
        chk({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
        chk({tag, "_sb_empty"}, 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;
        bus.mode = 0; bus.start = 0; bus.w_valid = 0; bus.w_row = 0;
        bus.w_data = '0; bus.in_valid = 0; bus.in_data = '0;
        bus.ps_data = '0; bus.in_last = 0; bus.out_ready = 1;
        repeat (2) @(posedge clk);
        #1 nRST = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_w_ready", 64'(bus.w_ready), 64'd1);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;

        // Identity weights, latency of ROWS+COLS edges.
        load_row(0, 1, 0);
        load_row(1, 0, 1);
        pulse_start(0, 1);
        send(3, 5, 0, 0, 0, 1);
        bus.in_valid = 0;
        chk("lat_0", 64'(bus.out_valid), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lat_%0d", k), 64'(bus.out_valid), 64'(k == 4));
        end
        wait_done("t1");

        // Signed extremes, with and without partial sums.
        load_row(0, -1, 2);
        load_row(1, 3, -4);
        pulse_start(0, 1);
        send(-128, 127, 0, 10, -10, 0);
        send(-128, 127, 1, 10, -10, 1);
        bus.in_valid = 0;
        wait_done("t2");

        // Back-to-back stream with a 3-cycle downstream stall.
        pulse_start(0, 1);
        send(1, 2, 0, 0, 0, 0);
        send(3, 4, 1, 100, 200, 0);
        bus.in_valid = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        chk("t3_first_out", 64'(seen), 64'd1);
        @(posedge clk); #1;
        bus.out_ready = 0;
        bus.in_valid  = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("t3_stall_out_valid", 64'(bus.out_valid), 64'd1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1;
        send(5, 6, 0, 0, 0, 0);
        send(7, 8, 1, -7, 9, 1);
        bus.in_valid = 0;
        wait_done("t3");

        // Reset with three vectors in flight.
        pulse_start(0, 1);
        send(1, 1, 0, 0, 0, 0);
        send(2, 2, 0, 0, 0, 0);
        send(3, 3, 0, 0, 0, 0);
        bus.in_valid = 0;
        nRST = 1'b1;
        @(posedge clk); #1;
        nRST = 1'b0;
        q.delete();
        chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_busy", 64'(bus.busy), 64'd0);
        chk("t5_out_data", bus.out_data, 64'd0);
        pulse_start(1, 0);
        repeat (4) @(posedge clk);
        #1 chk("t5_flushed", 64'(bus.out_valid), 64'd0);

        // Incomplete mask, then start together with the last row.
        load_row(0, 127, 127);
        pulse_start(1, 0);
        chk("t4_w_ready", 64'(bus.w_ready), 64'd1);
        W[1][0] = 127;
        W[1][1] = 127;
        bus.w_valid = 1;
        bus.w_row   = 1'b1;
        bus.w_data  = {8'd127, 8'd127};
        bus.start   = 1;
        @(posedge clk); #1;
        bus.w_valid = 0;
        bus.start   = 0;
        chk("t4_busy", 64'(bus.busy), 64'd1);
        chk("t4_cfg_err", 64'(bus.cfg_err), 64'd0);

        // Accumulator wrap-around.
        send(127, 127, 1, 32'h7FFF_FFFF, 0, 1);
        bus.in_valid = 0;
        wait_done("t6");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
